mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage that sits between the EX/MEM register and the MEM/WB register.
- Non-memory instructions pass straight through; loads and stores run a request/acknowledge transaction on a 32-bit data-memory bus.
- Stalls the pipeline until the transaction completes, then presents reg_write_ctrl/addr/data for the MEM/WB register to capture.
- Handles byte/half/word sizing, load sign/zero extension, misalignment and bus timeout.

Parameters:
- TIMEOUT, 16, REQ cycles without ack_i before a bus error; must be ≥1; counter width is clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  reset, asynchronous, active-high
- mem_read_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store (mem_read_i and mem_write_i both high is treated as load)
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_i  in  1  zero-extend loads when high, sign-extend when low
- alu_result_i  in  32  effective address, or the result for non-memory ops
- store_data_i  in  32  store data, right-aligned
- reg_write_ctrl_i  in  1  write-back enable from EX/MEM
- reg_write_addr_i  in  5  destination register
- stall_i  in  1  external pipeline stall
- reg_write_ctrl_o  out  1  to MEM/WB
- reg_write_addr_o  out  5  to MEM/WB
- reg_write_data_o  out  32  to MEM/WB
- stall_o  out  1  freeze upstream stages and MEM/WB
- err_o  out  1  one-cycle pulse: misaligned access or bus timeout
- req_o  out  1  bus request, held until ack
- we_o  out  1  bus write enable
- addr_o  out  32  word-aligned bus address ({addr[31:2],2'b00})
- be_o  out  4  byte enables, little-endian
- wdata_o  out  32  store data shifted to its byte lane
- ack_i  in  1  bus acknowledge; rdata_i valid in that cycle
- rdata_i  in  32  bus read data

Behaviour:
- Reset values (async):
  - state IDLE
  - req_o, we_o, err_o = 0
  - addr_o, be_o, wdata_o, captured read data, timeout counter = 0
  - stall_o forced to 0 while rst_i is high
- mem_op = mem_read_i | mem_write_i.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE:
  - Non-mem op: outputs = inputs, data = alu_result_i, stall_o = 0.
  - Aligned mem op: stall_o = 1. Next edge: latch the bus signals, req_o = 1, enter REQ.
  - Misaligned mem op: no request, stall_o = 0, reg_write_ctrl_o forced 0, err_o pulses on the next cycle.
- REQ:
  - stall_o = 1; bus outputs held stable.
  - Counter increments each cycle without ack_i.
  - On ack_i: req_o drops at the next edge. For loads, the extended rdata_i is captured. Go to DONE.
  - On count reaching TIMEOUT without ack_i: req_o drops, err_o pulses one cycle, write-back is suppressed, go to DONE.
  - If ack_i arrives in the same cycle the count reaches TIMEOUT, ack wins.
- DONE:
  - stall_o = 0 (asserted if stall_i is high).
  - Loads: reg_write_data_o = captured data. Stores and timeouts: reg_write_ctrl_o = 0.
  - Stays in DONE while stall_i is high; otherwise returns to IDLE at the next edge, when the pipeline advances.
- Latency: minimum 3 cycles per memory op (IDLE, REQ with ack, DONE), i.e. 2 stall cycles.
- ack_i outside REQ is ignored.
- stall_i in IDLE or REQ does not block the transaction.
- Stores:
  - byte: be = 0001 << addr[1:0], wdata = data[7:0] replicated ×4
  - half: be = 0011 << addr[1:0], wdata = data[15:0] replicated ×2
  - word: be = 1111
- Loads: select lane by addr[1:0], then extend per mem_unsigned_i.
- Reset mid-transaction: req_o drops immediately, state IDLE, no error pulse.

Decomposition:
- Package mem_stage_pkg:
  - size encodings SIZE_BYTE / SIZE_HALF / SIZE_WORD
  - state enum IDLE / REQ / DONE
- Sub-module load_align: combinational lane select plus sign/zero extend (rdata, addr[1:0], size, unsigned → 32-bit data); reusable.

Test Plan:
- Non-mem op, alu_result 0x12345678, dest 5, write 1 → outputs pass through the same cycle; stall_o 0; req_o never asserts.
- Signed byte load at 0x103, ack one cycle after req_o rises, rdata 0x80FFFFFF → exactly 3 stall cycles (IDLE + 2 REQ); DONE data 0xFFFFFF80, write 1, addr preserved.
- Half store 0xBEEF at 0x202, immediate ack → be_o 1100, wdata_o 0xBEEFBEEF, addr_o 0x200, we_o 1; DONE reg_write_ctrl_o 0.
- Word load at 0x101 → no req_o, stall_o 0, reg_write_ctrl_o 0, err_o high for exactly one cycle.
- TIMEOUT=4, no ack → req_o high 4 cycles then low; err_o pulses; write suppressed. Repeat with ack on the 4th cycle → ack wins, no error.
- Assert rst_i during REQ → req_o falls immediately; after release, state is IDLE and a new load completes normally. stall_i held 3 cycles in DONE → outputs held, then return to IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Halves must sit on even addresses, words on multiples of four; size 11 behaves as word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return addr_lo[0];
         default:   return (addr_lo != 2'b00);
      endcase
   endfunction

   // Little-endian byte enables for an aligned access.
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: return 4'b0001 << addr_lo;
         SIZE_HALF: return 4'b0011 << addr_lo;
         default:   return 4'b1111;
      endcase
   endfunction

   // Replicate right-aligned store data across every lane it could occupy.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_BYTE: return {4{data[7:0]}};
         SIZE_HALF: return {2{data[15:0]}};
         default:   return data;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Bring the addressed lane down to bit 0; halves are aligned so this shifts by 0 or 16.
   assign shifted = rdata >> {addr_lo, 3'b000};

   // Extend the selected lane to 32 bits.
   always_comb begin
      data = rdata;
      case (size)
         SIZE_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: pass-through for ALU ops, req/ack bus transaction for loads/stores.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | pass-through; an aligned load/store stalls and launches a request
// REQ   | req_o held with stable bus signals until ack_i or timeout
// DONE  | result presented to MEM/WB; held while stall_i is high
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  mem_size_i,
   input  logic        mem_unsigned_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic        reg_write_ctrl_i,
   input  logic [4:0]  reg_write_addr_i,
   input  logic        stall_i,
   output logic        reg_write_ctrl_o,
   output logic [4:0]  reg_write_addr_o,
   output logic [31:0] reg_write_data_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        req_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic        ack_i,
   input  logic [31:0] rdata_i
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           load_q;
   logic           ctrl_q;
   logic           tmo_q;
   logic           uns_q;
   logic [4:0]     waddr_q;
   logic [1:0]     size_q;
   logic [1:0]     lo_q;
   logic [31:0]    rdata_q;
   logic [31:0]    ext_data;
   logic           mem_op;
   logic           misaligned;

   assign mem_op     = mem_read_i | mem_write_i;
   assign misaligned = is_misaligned(mem_size_i, alu_result_i[1:0]);

   load_align u_load_align (
      .rdata       (rdata_i),
      .addr_lo     (lo_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .data        (ext_data)
   );

   // Transaction FSM with registered bus outputs, error pulse and captured load data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         req_o   <= 1'b0;
         we_o    <= 1'b0;
         err_o   <= 1'b0;
         addr_o  <= '0;
         be_o    <= '0;
         wdata_o <= '0;
         rdata_q <= '0;
         cnt     <= '0;
         load_q  <= 1'b0;
         ctrl_q  <= 1'b0;
         tmo_q   <= 1'b0;
         uns_q   <= 1'b0;
         waddr_q <= '0;
         size_q  <= '0;
         lo_q    <= '0;
      end else begin
         err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_op) begin
                  if (misaligned) begin
                     err_o <= 1'b1;
                  end else begin
                     req_o   <= 1'b1;
                     // both read and write high is treated as a load
                     we_o    <= ~mem_read_i;
                     addr_o  <= {alu_result_i[31:2], 2'b00};
                     be_o    <= byte_enables(mem_size_i, alu_result_i[1:0]);
                     wdata_o <= store_lanes(mem_size_i, store_data_i);
                     load_q  <= mem_read_i;
                     ctrl_q  <= reg_write_ctrl_i;
                     waddr_q <= reg_write_addr_i;
                     size_q  <= mem_size_i;
                     lo_q    <= alu_result_i[1:0];
                     uns_q   <= mem_unsigned_i;
                     tmo_q   <= 1'b0;
                     cnt     <= '0;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               if (ack_i) begin
                  // ack beats a timeout landing in the same cycle
                  req_o <= 1'b0;
                  if (load_q) begin
                     rdata_q <= ext_data;
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == TO_LAST) begin
                     req_o <= 1'b0;
                     err_o <= 1'b1;
                     tmo_q <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (!stall_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall and MEM/WB-facing outputs, selected by state.
   always_comb begin
      stall_o          = 1'b0;
      reg_write_ctrl_o = reg_write_ctrl_i;
      reg_write_addr_o = reg_write_addr_i;
      reg_write_data_o = alu_result_i;
      case (state)
         IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  reg_write_ctrl_o = 1'b0;
               end else begin
                  stall_o = 1'b1;
               end
            end
         end
         REQ: stall_o = 1'b1;
         DONE: begin
            stall_o          = stall_i;
            reg_write_ctrl_o = ctrl_q & load_q & ~tmo_q;
            reg_write_addr_o = waddr_q;
            reg_write_data_o = rdata_q;
         end
         default: ;
      endcase
      if (rst_i) begin
         stall_o = 1'b0;
      end
   end

endmodule
